// File: rtl/div_pkg.sv
// Shared constants for the repeated-subtraction divider: default operand width
// and controller state encodings.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 16;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_LOADB_ENC = 2'd1;
  localparam logic [1:0] ST_RUN_ENC   = 2'd2;
  localparam logic [1:0] ST_DONE_ENC  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_LOADB = ST_LOADB_ENC,
    ST_RUN   = ST_RUN_ENC,
    ST_DONE  = ST_DONE_ENC
  } div_state_e;

endpackage : div_pkg

// File: rtl/div_datapath.sv
// Divider datapath: remainder, divisor and quotient registers plus the
// guarded subtractor and the compare/zero status fed back to the controller.
module div_datapath
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_a_i,
  input  logic             load_b_i,
  input  logic             dec_i,
  input  logic [WIDTH-1:0] datain_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             ge_o,
  output logic             eqz_o
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = WIDTH'(0);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;

  // Next-state for remainder/quotient (load or subtract step) and divisor (load).
  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    if (load_a_i) begin
      rem_d = datain_i;
      quo_d = ZERO;
    end else if (dec_i) begin
      rem_d = rem_q - dvs_q;
      quo_d = quo_q + ONE;
    end else begin
      rem_d = rem_q;
      quo_d = quo_q;
    end
    if (load_b_i) begin
      dvs_d = datain_i;
    end else begin
      dvs_d = dvs_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= ZERO;
      dvs_q <= ZERO;
      quo_q <= ZERO;
    end else begin
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      quo_q <= quo_d;
    end
  end

  assign ge_o        = (rem_q >= dvs_q);
  assign eqz_o       = (dvs_q == ZERO);
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule : div_datapath

// File: rtl/div_repsub.sv
// Unsigned repeated-subtraction divider: controller FSM driving div_datapath.
// Operands arrive on one bus in consecutive cycles; results come with a done pulse.
module div_repsub
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] datain,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divz
);

  div_state_e state_q, state_d;
  logic       divz_q, divz_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       load_a_s, load_b_s, dec_s;
  logic       ge_s, eqz_s;

  div_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk         (clk),
    .rst         (rst),
    .load_a_i    (load_a_s),
    .load_b_i    (load_b_s),
    .dec_i       (dec_s),
    .datain_i    (datain),
    .quotient_o  (quotient),
    .remainder_o (remainder),
    .ge_o        (ge_s),
    .eqz_o       (eqz_s)
  );

  // Controller next-state, datapath strobes and divide-by-zero flag.
  always_comb begin
    state_d  = state_q;
    divz_d   = divz_q;
    load_a_s = 1'b0;
    load_b_s = 1'b0;
    dec_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load_a_s = 1'b1;
          divz_d   = 1'b0;
          state_d  = ST_LOADB;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_LOADB: begin
        load_b_s = 1'b1;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        // Zero divisor is tested first: with divisor 0 the compare is always true.
        if (eqz_s) begin
          divz_d  = 1'b1;
          state_d = ST_DONE;
        end else if (ge_s) begin
          dec_s   = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy_d = (state_d != ST_IDLE);
  assign done_d = (state_d == ST_DONE);

  // State and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      divz_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      divz_q  <= divz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign divz = divz_q;

endmodule : div_repsub

// File: tb/tb_div_repsub.sv
// Scoreboard bench for div_repsub: driver pushes expected results and done cycle,
// an independent monitor pops and compares on each done pulse.
module tb_div_repsub;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] datain;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        divz;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   pushes = 0;
  int   dones  = 0;

  div_repsub #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .datain    (datain),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .divz      (divz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue one operation; expected values come from plain integer division.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input bit push);
    exp_t e;
    @(negedge clk);
    start  = 1'b1;
    datain = a;
    @(negedge clk);
    start  = 1'b0;
    datain = b;
    if (b == 16'd0) begin
      e.q = 16'd0;
      e.r = a;
      e.z = 1'b1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.z = 1'b0;
    end
    e.cyc = cyc + int'(e.q) + 2;
    if (push) begin
      sb.push_back(e);
      pushes++;
    end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      if (i == 0) datain = 16'($urandom);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_timeout", 32'(ok), 32'd1);
  endtask

  // Monitor: compare each done pulse against the scoreboard head.
  initial begin
    exp_t e;
    bit prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_done = 1'b0;
      end else begin
        if (prev_done) begin
          chk("busy_after_done", 32'(busy), 32'd0);
          chk("done_single_pulse", 32'(done), 32'd0);
        end
        if (done) begin
          dones++;
          chk("busy_with_done", 32'(busy), 32'd1);
          if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("quotient", 32'(quotient), 32'(e.q));
            chk("remainder", 32'(remainder), 32'(e.r));
            chk("divz", 32'(divz), 32'(e.z));
            chk("done_latency", 32'(cyc), 32'(e.cyc));
          end
        end
        prev_done = done;
      end
    end
  end

  initial begin
    bit seen;
    logic [15:0] a, b;
    rst    = 1'b1;
    start  = 1'b0;
    datain = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_divz", 32'(divz), 32'd0);
    rst = 1'b0;

    issue(16'd100, 16'd7, 1'b1);   wait_idle();
    issue(16'd5, 16'd9, 1'b1);     wait_idle();
    issue(16'd0, 16'd5, 1'b1);     wait_idle();
    issue(16'd1234, 16'd0, 1'b1);  wait_idle();
    issue(16'd10, 16'd3, 1'b1);    wait_idle();

    // start pulses in a RUN cycle and in the DONE cycle must be ignored
    issue(16'd100, 16'd7, 1'b1);
    repeat (5) @(negedge clk);
    start  = 1'b1;
    datain = 16'd50;
    @(negedge clk);
    start  = 1'b0;
    seen   = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("done_seen_for_ignore", 32'(seen), 32'd1);
    start  = 1'b1;
    datain = 16'd50;
    @(negedge clk);
    start  = 1'b0;
    chk("ignored_start_busy", 32'(busy), 32'd0);
    chk("ignored_start_q", 32'(quotient), 32'd14);
    chk("ignored_start_r", 32'(remainder), 32'd2);
    repeat (3) @(negedge clk);
    chk("ignored_start_idle", 32'(busy), 32'd0);

    issue(16'd65535, 16'd1, 1'b1); wait_idle();

    // async reset mid-RUN aborts with all outputs cleared immediately
    issue(16'd1000, 16'd3, 1'b0);
    repeat (20) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_quotient", 32'(quotient), 32'd0);
    chk("arst_remainder", 32'(remainder), 32'd0);
    chk("arst_divz", 32'(divz), 32'd0);
    #1 rst = 1'b0;
    issue(16'd20, 16'd4, 1'b1);    wait_idle();

    for (int n = 0; n < 16; n++) begin
      if (n < 12) begin
        a = 16'($urandom_range(0, 600));
        b = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
      end else begin
        a = 16'($urandom);
        b = 16'($urandom_range(256, 65535));
      end
      issue(a, b, 1'b1);
      wait_idle();
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    chk("done_count", 32'(dones), 32'(pushes));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_div_repsub

// File: doc/div_repsub.md
Name: div_repsub

Overview:
Unsigned integer divider using repeated subtraction. It is the inverse counterpart of the repeated-addition multiplier and reuses the same operand-load style: dividend and divisor arrive on one shared data bus in consecutive cycles. It contains both the controller FSM and the datapath (remainder register, divisor register, quotient counter, subtractor, compare). Quotient, remainder and a divide-by-zero flag are returned with a one-cycle done pulse.

Parameters:
WIDTH, 16, operand/result width in bits (dividend, divisor, quotient, remainder)

Ports:
clk  in  1  system clock, rising-edge active
rst  in  1  reset, asynchronous, active-high
start  in  1  request; sampled only in IDLE; datain carries the dividend in the same cycle
datain  in  WIDTH  shared operand bus: dividend in the start cycle, divisor in the next cycle
busy  out  1  high from the cycle after start is accepted until done is asserted (inclusive)
done  out  1  one-cycle pulse; quotient, remainder and divz are valid from this cycle
quotient  out  WIDTH  registered floor(dividend/divisor)
remainder  out  WIDTH  registered dividend mod divisor
divz  out  1  registered divide-by-zero flag

Behaviour:
- Reset (async, rst=1): state=IDLE; quotient, remainder, divisor reg, divz, busy and done all 0. Asserting reset mid-operation aborts the operation immediately. No partial result is kept.
- States: IDLE, LOADB, RUN, DONE.
- IDLE: busy=0.
  - start=1 at a rising edge: remainder<=datain, quotient<=0, divz<=0, go to LOADB.
  - start=0: hold all outputs.
- LOADB: divisor reg<=datain (unconditional), go to RUN.
- RUN, evaluated at each edge:
  - divisor==0: divz<=1, go to DONE; quotient=0, remainder=dividend.
  - remainder>=divisor (unsigned): remainder<=remainder-divisor, quotient<=quotient+1, stay in RUN.
  - otherwise: go to DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then go to IDLE. Results hold until the next accepted start.
- Latency: number the start-sampling edge as edge 1. done is high in the cycle after edge q+3, where q is the quotient. Divide-by-zero behaves as q=0. Worst case is 65535/1, with done after edge 65538.
- Arithmetic:
  - Subtraction never underflows because it is guarded by the compare.
  - Quotient cannot exceed 2^WIDTH-1, so no wrap occurs.
- Dividend 0 with a nonzero divisor gives Q=0, R=0 with q=0 latency.
- start while busy, including the DONE cycle, is ignored. No queuing and no effect on the results.
- datain is don't-care outside the start cycle and the LOADB cycle.
- done and busy are registered outputs decoded from state; no combinational path from inputs to outputs.

Decomposition:
- Shared package div_pkg holds:
  - the state encodings (IDLE=2'd0, LOADB=2'd1, RUN=2'd2, DONE=2'd3) as localparams;
  - the default WIDTH constant.
- One sub-module, div_datapath, holds the remainder register, divisor register, quotient counter, subtractor and the ge/eqz status outputs.
- div_repsub holds the controller FSM and drives the datapath load/dec/clear strobes, matching the team's datapath/control split.

Test Plan:
1. start with datain=100, next cycle datain=7 -> Q=14, R=2, divz=0, done single pulse after edge 17, busy low in the following cycle.
2. 5 then 9 -> Q=0, R=5, done after edge 3; also 0 then 5 -> Q=0, R=0, done after edge 3.
3. 1234 then 0 -> divz=1, Q=0, R=1234, done after edge 3; the next valid op 10/3 -> divz=0, Q=3, R=1.
4. 65535 then 1 -> Q=65535, R=0, done after edge 65538, no quotient wrap.
5. During 100/7, pulse start with datain=50 in a RUN cycle and again in the DONE cycle -> both ignored; result stays Q=14, R=2; exactly one done pulse.
6. rst pulsed mid-RUN of 1000/3 -> outputs 0 and busy 0 immediately (async); then 20/4 -> Q=5, R=0, done after edge 8.
